sm_clkdiv_sched: RTL and testbench

// - Per-state-machine clock-enable scheduler for the PIO block.
// - Consumes SM_ENABLE (CTRL[3:0]), CLKDIV_RESTART (CTRL[11:8], single-cycle

---
 rtl/sm_clkdiv_sched.sv | 98 +++++++++
 tb/tb_sm_clkdiv_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_clkdiv_sched.sv
// -----------------------------------------------------------------------------
// sm_clkdiv_sched
//
// Per-state-machine clock-enable scheduler for the PIO block. Each state
// machine owns an independent fractional divider. The divider emits one
// registered execute-enable pulse per period of INT + FRAC/256 cycles. INT = 0
// selects a divisor of 65536. Each SM executes an instruction only in cycles
// where its clk_en bit is high.
//
// Ports
//   clk             system clock; all state updates on the rising edge
//   rst             asynchronous, active-high reset
//   sm_enable       per-SM run enable (level); low freezes that SM's divider
//   clkdiv_restart  per-SM one-cycle pulse that clears the divider phase
//   clkdiv_flat     SMn_CLKDIV packed at [32n+31:32n]:
//                   INT in [31:16], FRAC in [15:8], [7:0] unused
//   clk_en          registered execute-enable pulse per SM
// -----------------------------------------------------------------------------
module sm_clkdiv_sched #(
    parameter int NUM_SM = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SM-1:0]    sm_enable,
    input  logic [NUM_SM-1:0]    clkdiv_restart,
    input  logic [32*NUM_SM-1:0] clkdiv_flat,
    output logic [NUM_SM-1:0]    clk_en
);

    genvar i;
    generate
        for (i = 0; i < NUM_SM; i++) begin : g_sm
            logic [INT_W-1:0]  div_int;
            logic [FRAC_W-1:0] div_frac;
            logic [INT_W-1:0]  cnt;        // enabled cycles left before the next pulse
            logic [FRAC_W-1:0] acc;        // fractional phase carried between periods
            logic [INT_W-1:0]  cnt_reload;
            logic [FRAC_W-1:0] acc_reload;
            logic [FRAC_W:0]   frac_sum;
            logic              en_q;
            logic              unused_low_bits;

            assign div_int         = clkdiv_flat[32*i+16 +: INT_W];
            assign div_frac        = clkdiv_flat[32*i+16-FRAC_W +: FRAC_W];
            assign unused_low_bits = ^clkdiv_flat[32*i +: 16-FRAC_W];

            // Reload values for the period that starts at this pulse. The
            // fractional carry stretches the gap by one cycle; since
            // INT >= 1 here, INT - 1 + carry cannot overflow INT_W bits.
            // NOTE: every variable gets a value on every path through an
            // always_comb block; any path that leaves one unassigned infers
            // a latch.
            always_comb begin
                frac_sum   = {1'b0, acc} + {1'b0, div_frac};
                cnt_reload = div_int - INT_W'(1) + INT_W'(frac_sum[FRAC_W]);
                acc_reload = frac_sum[FRAC_W-1:0];
                if (div_int == '0) begin
                    // Divisor of 2^INT_W. The count wraps to all-ones and
                    // FRAC is ignored, so the phase holds.
                    cnt_reload = '1;
                    acc_reload = acc;
                end
            end

            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values; blocking assignments here
            // would make the result depend on statement order.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_q <= 1'b0;
                    cnt  <= '0;
                    acc  <= '0;
                end else if (clkdiv_restart[i]) begin
                    // Restart overrides the enable. The next enabled edge
                    // pulses because cnt is 0.
                    en_q <= 1'b0;
                    cnt  <= '0;
                    acc  <= '0;
                end else if (!sm_enable[i]) begin
                    // Frozen. The remaining gap is preserved for re-enable.
                    en_q <= 1'b0;
                end else if (cnt != '0) begin
                    en_q <= 1'b0;
                    cnt  <= cnt - INT_W'(1);
                end else begin
                    en_q <= 1'b1;
                    cnt  <= cnt_reload;
                    acc  <= acc_reload;
                end
            end

            assign clk_en[i] = en_q;
        end
    endgenerate

endmodule

// File: tb/tb_sm_clkdiv_sched.sv
// -----------------------------------------------------------------------------
// tb_sm_clkdiv_sched
//
// The reference model runs once per clock edge. It keeps, for each SM, the
// number of enabled edges left until the next pulse and the fractional phase
// in 1/256 units. It derives each gap from the divisor by fixed-point division.
// The expected clk_en vector for every cycle is queued. A separate monitor
// pops the queue on the falling edge and compares it with the DUT. Directed
// sequences add explicit checks on pulse counts, gaps, lockstep behaviour and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_sm_clkdiv_sched;
    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    sm_enable;
    logic [N-1:0]    clkdiv_restart;
    logic [32*N-1:0] clkdiv_flat;
    logic [N-1:0]    clk_en;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_q[$];

    sm_clkdiv_sched #(.NUM_SM(N), .INT_W(16), .FRAC_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .sm_enable      (sm_enable),
        .clkdiv_restart (clkdiv_restart),
        .clkdiv_flat    (clkdiv_flat),
        .clk_en         (clk_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // The low byte of each divisor word is filled with noise. That byte
    // must not affect the result.
    task automatic set_div(input int sm, input int intv, input int frac);
        clkdiv_flat[32*sm +: 32] = {intv[15:0], frac[7:0], 8'($urandom)};
    endtask

    // Reference model. Inputs change only on falling edges, so the values
    // read here are the values the DUT samples at this rising edge.
    initial begin : model
        int     left [N];
        longint phase[N];
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    left[i]  = 0;
                    phase[i] = 0;
                end
                exp_q.delete();
                exp_q.push_back('0);
            end else begin
                logic [N-1:0] e;
                e = '0;
                for (int i = 0; i < N; i++) begin
                    int     intv;
                    int     frac;
                    longint d;
                    longint s;
                    intv = int'(clkdiv_flat[32*i+16 +: 16]);
                    frac = int'(clkdiv_flat[32*i+8 +: 8]);
                    if (clkdiv_restart[i]) begin
                        left[i]  = 0;
                        phase[i] = 0;
                    end else if (sm_enable[i]) begin
                        if (left[i] > 0) begin
                            left[i]--;
                        end else begin
                            // Divisor in 1/256 units; INT = 0 means 65536.0
                            d = (intv == 0) ? 64'd65536 * 256 : longint'(intv) * 256 + frac;
                            s = phase[i] + d;
                            e[i]     = 1'b1;
                            left[i]  = int'(s / 256) - 1;
                            phase[i] = s % 256;
                        end
                    end
                end
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: one expected vector per cycle
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                check("sb_clk_en", longint'(clk_en), longint'(e));
            end
        end
    end

    task automatic wait_pulse(input int sm, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (clk_en[sm]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_ones(input int sm, input int cycles, output int ones);
        ones = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (clk_en[sm]) ones++;
        end
    endtask

    task automatic pulse_restart(input logic [N-1:0] mask);
        clkdiv_restart = mask;
        @(negedge clk);
        clkdiv_restart = '0;
    endtask

    initial begin : stim
        int ones;
        int hi;
        int gap;
        int mism;
        int p0;
        bit ok;

        rst            = 1'b0;
        sm_enable      = '0;
        clkdiv_restart = '0;
        for (int i = 0; i < N; i++) set_div(i, 1, 0);

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_clk_en", longint'(clk_en), 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: period 1 keeps clk_en[0] high from the cycle after the first
        // enabled edge. The other SMs stay idle.
        set_div(0, 1, 0);
        sm_enable = 4'b0001;
        ones = 0;
        hi   = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (clk_en[0]) ones++;
            if (clk_en[3:1] != 3'b000) hi++;
        end
        check("t1_continuous", ones, 20);
        check("t1_others_idle", hi, 0);

        // T2: divide by 3
        set_div(1, 3, 0);
        sm_enable[1] = 1'b1;
        pulse_restart(4'b0010);
        count_ones(1, 30, ones);
        check("t2_div3_pulses", ones, 10);

        // T3: divide by 2.5; gaps alternate 2 and 3
        set_div(2, 2, 8'h80);
        sm_enable[2] = 1'b1;
        pulse_restart(4'b0100);
        wait_pulse(2, 10, ok);
        check("t3_first_pulse", ok, 1);
        count_ones(2, 10, ones);
        check("t3_frac_pulses", ones, 4);

        // T5: freeze mid-gap, then lockstep after a joint restart
        set_div(0, 5, 0);
        set_div(1, 5, 0);
        sm_enable = 4'b0011;
        pulse_restart(4'b0011);
        wait_pulse(0, 10, ok);
        check("t5_first_pulse", ok, 1);
        repeat (2) @(negedge clk);
        sm_enable[0] = 1'b0;
        repeat (7) @(negedge clk);
        sm_enable[0] = 1'b1;
        gap = 9;
        ok  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            gap++;
            if (clk_en[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_freeze_timeout", ok, 1);
        check("t5_freeze_gap", gap, 12);

        pulse_restart(4'b0011);
        mism = 0;
        p0   = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (clk_en[0] != clk_en[1]) mism++;
            if (clk_en[0]) p0++;
        end
        check("t5_lockstep_mismatch", mism, 0);
        check("t5_lockstep_pulses", p0, 8);

        // Randomized traffic: enables, restarts and divisor changes
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                sm_enable[i]      = ($urandom_range(0, 7) != 0);
                clkdiv_restart[i] = ($urandom_range(0, 31) == 0);
            end
            if ($urandom_range(0, 63) == 0)
                set_div(int'($urandom_range(0, N-1)), int'($urandom_range(1, 6)),
                        int'($urandom_range(0, 255)));
        end
        @(negedge clk);
        clkdiv_restart = '0;

        // T4: INT = 0 gives a 65536-cycle period, and FRAC is ignored
        sm_enable = 4'b1000;
        set_div(3, 0, 8'hFF);
        pulse_restart(4'b1000);
        wait_pulse(3, 10, ok);
        check("t4_first_pulse", ok, 1);
        gap = 0;
        ok  = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            @(negedge clk);
            gap++;
            if (clk_en[3]) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_wrap_timeout", ok, 1);
        check("t4_wrap_gap", gap, 65536);

        // T6: asynchronous reset while all SMs are pulsing
        for (int i = 0; i < N; i++) set_div(i, i + 1, int'($urandom_range(0, 255)));
        sm_enable = 4'b1111;
        pulse_restart(4'b1111);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("t6_async_clear", longint'(clk_en), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_first_after_reset", longint'(clk_en), 15);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
